pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. It drives the `EN`/`flush` pair of each pipeline register (`IF_ID`, `ID_EX`, `EX_MEM`, `MEM_WB`) and the PC enable. It does this from memory-hit, load-use, branch-mispredict and halt conditions. It owns the halt drain sequence and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- `CNT_W`, 16: width of the performance counters.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch complete this cycle.
- `dhit`  in  1  data access complete this cycle.
- `exmem_dREN`, `exmem_dWEN`  in  1 each  MEM-stage data request (`EX_MEM` outputs).
- `idex_dREN`  in  1  EX-stage instruction is a load.
- `idex_wsel`  in  5  EX-stage destination register.
- `ifid_rs`, `ifid_rt`  in  5 each  ID-stage source registers.
- `ex_mispredict`  in  1  EX-stage branch/jump resolved against the prediction.
- `idex_halt`  in  1  halt instruction in EX.
- `memwb_halt`  in  1  halt instruction in WB.
- `pc_en`  out  1  PC register load enable.
- `ifid_en`, `ifid_flush`, `idex_en`, `idex_flush`, `exmem_en`, `exmem_flush`, `memwb_en`, `memwb_flush`  out  1 each  pipeline register controls.
- `halt`  out  1  sticky processor halt.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters.

## Operation
Derived terms:
- `dstall` = (`exmem_dREN` | `exmem_dWEN`) & ~`dhit`.
- `lu` = `idex_dREN` & (`idex_wsel` != 0) & (`idex_wsel` == `ifid_rs` | `idex_wsel` == `ifid_rt`).
- `mp` = `ex_mispredict` & ~`dstall`.

Cases are evaluated in fixed priority order; only the first match applies. "Normal" means en=1, flush=0 for every register, and `pc_en` = `ihit`.

1. **HALTED:** every en=0, every flush=0, `pc_en`=0, `halt`=1.
2. **`dstall`:** `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0. `memwb_en`=1 and `memwb_flush`=1, which inserts a WB bubble.
3. **`mp`:** `pc_en`=1 (PC loads the corrected target). `ifid_flush`=1 and `idex_flush`=1, each with its en=1. `EX_MEM` and `MEM_WB` are normal.
4. **`lu`:** `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_flush`=1. `EX_MEM` and `MEM_WB` are normal.
5. **~`ihit` or state DRAIN:** `pc_en`=0, `ifid_en`=1, `ifid_flush`=1. Later stages are normal.
6. **Otherwise:** normal.

FSM (`state_t`: RUN, DRAIN, HALTED):
- RUN -> DRAIN when `idex_halt` & ~`dstall`.
- DRAIN -> HALTED when `memwb_halt`.
- RUN -> HALTED directly when `memwb_halt` (covers a missed DRAIN entry).
- HALTED is absorbing until `nRST`.
- In DRAIN, `mp` and `lu` still apply with their normal priority. Fetch stays suppressed regardless of `ihit`.

Counters:
- `stall_cnt` increments on every cycle in case 2, 4 or 5 while not HALTED.
- `flush_cnt` increments on every case-3 cycle.
- Both saturate at all-ones; they do not wrap.

## Timing
- Reset values: state=RUN, `halt`=0, both counters 0. Because the controls are combinational, during reset they follow RUN (assuming ~`ihit`: `pc_en`=0, IF_ID bubble).
- All en/flush outputs are combinational from the inputs and the current state, with zero-cycle latency. This lets the pipeline registers act in the same edge.
- `halt` is registered: it asserts the cycle after `memwb_halt` is sampled high.
- Counters and state update on the rising edge of `CLK`.
- **Simultaneous `dstall` and `ex_mispredict`:** the mispredict is ignored that cycle. It is re-evaluated when the freeze releases, because EX is held.
- **Simultaneous `lu` and `mp`:** the flush wins and the load-use stall is dropped (the ID instruction is discarded).
- **`dhit` in the same cycle as the request:** no stall cycle.
- Asserting `nRST` mid-drain or while HALTED returns the block to RUN immediately (asynchronous).

## Structure
- `state_t` goes in `cpu_types_pkg`.
- The block is a single module with no sub-modules. One `always_ff` holds state and counters; one `always_comb` produces the controls.
- `CNT_W` stays local.

## Test plan
1. **Load-use:** `idex_dREN`=1, `idex_wsel`=5, `ifid_rs`=5, `ihit`=1 -> `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall_cnt` becomes 1 after the edge. With `idex_wsel`=0 -> no stall.
2. **Data miss:** `exmem_dREN`=1 with `dhit` low for 3 cycles, then high -> 3 cycles of `exmem_en`=0 with `memwb_flush`=1, then normal; `stall_cnt` reaches 3.
3. **Mispredict during `dstall`:** `ex_mispredict`=1 while `dhit`=0 -> no flush. On the `dhit` cycle -> `ifid_flush`=1, `idex_flush`=1, `pc_en`=1, `flush_cnt` becomes 1.
4. **Halt:** `idex_halt` pulse, then `memwb_halt` two cycles later -> fetch suppressed during DRAIN. `halt`=1 the cycle after `memwb_halt`, and every en=0 thereafter. Later `ihit`=1 -> remains halted.
5. **Saturation:** drive `CNT_W`=4 with a permanent ~`ihit` for 20 cycles -> `stall_cnt` holds at 15.
6. **Reset:** pull `nRST` low mid-DRAIN -> state RUN and counters 0 with no clock edge; `halt`=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller sequencing states.
package cpu_types_pkg;

  // RUN: normal flow; DRAIN: halt seen in EX, fetch suppressed; HALTED: absorbing
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: drives the
// en/flush pairs of each pipeline register and the PC enable, owns the halt
// drain sequence and keeps saturating stall/flush counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_wsel,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ex_mispredict,
  input  logic             idex_halt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dstall, lu, mp;
  logic stall_evt, flush_evt;

  assign dstall = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign lu     = idex_dREN & (idex_wsel != 5'd0) &
                  ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));
  // A frozen EX holds the branch, so the mispredict is re-seen after the freeze.
  assign mp     = ex_mispredict & ~dstall;

  // State and performance counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state for the halt sequencer and saturating counter updates
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        // memwb_halt wins so a missed DRAIN entry still halts
        if (memwb_halt) begin
          state_d = HALTED;
        end else if (idex_halt && !dstall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (memwb_halt) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Priority-ordered pipeline register controls, combinational from inputs and state
  always_comb begin
    pc_en       = ihit;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dstall) begin
      // Freeze everything up to MEM, push a bubble into WB
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      stall_evt   = 1'b1;
    end else if (mp) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_evt  = 1'b1;
    end else if (!ihit || (state_q == DRAIN)) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      stall_evt  = 1'b1;
    end
  end

  assign halt      = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipeline_ctrl;

  localparam int HOLD = 0, LOAD = 1, BUBBLE = 2;

  logic clk = 1'b0;
  logic nrst;
  logic ihit, dhit, exmem_dren, exmem_dwen, idex_dren, ex_mispredict, idex_halt, memwb_halt;
  logic [4:0] idex_wsel, ifid_rs, ifid_rt;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4;
  logic exmem_en4, exmem_flush4, memwb_en4, memwb_flush4, halt4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_drain, m_halt;
  int m_stall, m_flush, m_stall4, m_flush4;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dren), .exmem_dWEN(exmem_dwen), .idex_dREN(idex_dren),
    .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ex_mispredict(ex_mispredict), .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dren), .exmem_dWEN(exmem_dwen), .idex_dREN(idex_dren),
    .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ex_mispredict(ex_mispredict), .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .idex_en(idex_en4), .idex_flush(idex_flush4), .exmem_en(exmem_en4),
    .exmem_flush(exmem_flush4), .memwb_en(memwb_en4), .memwb_flush(memwb_flush4),
    .halt(halt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // Expected register controls as a packed vector {ifid, idex, exmem, memwb} x {en, flush}
  function automatic logic [7:0] act_vec(input int a0, input int a1, input int a2, input int a3);
    int a [4];
    logic [7:0] v;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int i = 0; i < 4; i++) begin
      v[7 - 2 * i] = (a[i] != HOLD);
      v[6 - 2 * i] = (a[i] == BUBBLE);
    end
    return v;
  endfunction

  // Compare process: every negedge, check DUT outputs against the model, then advance it
  always @(negedge clk) begin
    bit ds, lu, pc, st_ev, fl_ev;
    logic [7:0] ctl;
    if (!nrst) begin
      m_drain = 0; m_halt = 0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end
    ds = (exmem_dren || exmem_dwen) && !dhit;
    lu = idex_dren && (idex_wsel != 0) && (idex_wsel == ifid_rs || idex_wsel == ifid_rt);
    st_ev = 0; fl_ev = 0;
    if (m_halt) begin
      pc = 0; ctl = act_vec(HOLD, HOLD, HOLD, HOLD);
    end else if (ds) begin
      pc = 0; ctl = act_vec(HOLD, HOLD, HOLD, BUBBLE); st_ev = 1;
    end else if (ex_mispredict) begin
      pc = 1; ctl = act_vec(BUBBLE, BUBBLE, LOAD, LOAD); fl_ev = 1;
    end else if (lu) begin
      pc = 0; ctl = act_vec(HOLD, BUBBLE, LOAD, LOAD); st_ev = 1;
    end else if (!ihit || m_drain) begin
      pc = 0; ctl = act_vec(BUBBLE, LOAD, LOAD, LOAD); st_ev = 1;
    end else begin
      pc = 1; ctl = act_vec(LOAD, LOAD, LOAD, LOAD);
    end
    chk("pc_en", {31'd0, pc_en}, {31'd0, pc});
    chk("ctl", {24'd0, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush}, {24'd0, ctl});
    chk("ctl4", {23'd0, pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4,
                 exmem_en4, exmem_flush4, memwb_en4, memwb_flush4}, {23'd0, pc, ctl});
    chk("halt", {31'd0, halt}, {31'd0, m_halt});
    chk("halt4", {31'd0, halt4}, {31'd0, m_halt});
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
    chk("stall_cnt4", {28'd0, stall_cnt4}, m_stall4);
    chk("flush_cnt4", {28'd0, flush_cnt4}, m_flush4);
    // Inputs stay put until after the next posedge, so advancing here matches the edge
    if (nrst) begin
      if (st_ev) begin
        m_stall = sat_inc(m_stall, 65535); m_stall4 = sat_inc(m_stall4, 15);
      end
      if (fl_ev) begin
        m_flush = sat_inc(m_flush, 65535); m_flush4 = sat_inc(m_flush4, 15);
      end
      if (!m_halt) begin
        if (memwb_halt) begin
          m_halt = 1; m_drain = 0;
        end else if (!m_drain && idex_halt && !ds) begin
          m_drain = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; exmem_dren = 0; exmem_dwen = 0; idex_dren = 0;
    ex_mispredict = 0; idex_halt = 0; memwb_halt = 0;
    idex_wsel = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    nrst = 0;
    step();
    nrst = 1;
  endtask

  initial begin
    nrst = 0;
    clear_inputs();
    repeat (2) step();
    // Reset state
    chk("rst_stall", {16'd0, stall_cnt}, 0);
    chk("rst_halt", {31'd0, halt}, 0);
    chk("rst_pc_en", {31'd0, pc_en}, 0);
    chk("rst_ifid_flush", {31'd0, ifid_flush}, 1);
    nrst = 1;

    // Load-use
    do_reset();
    ihit = 1; idex_dren = 1; idex_wsel = 5; ifid_rs = 5; ifid_rt = 9;
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 1);
    step();
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 1);
    idex_wsel = 0; ifid_rs = 0;
    #1;
    chk("lu_r0_pc_en", {31'd0, pc_en}, 1);
    chk("lu_r0_idex_flush", {31'd0, idex_flush}, 0);

    // Data miss for three cycles
    do_reset();
    ihit = 1; exmem_dren = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_exmem_en", {31'd0, exmem_en}, 0);
      chk("miss_memwb_flush", {31'd0, memwb_flush}, 1);
      step();
    end
    dhit = 1;
    #1;
    chk("hit_exmem_en", {31'd0, exmem_en}, 1);
    chk("hit_memwb_flush", {31'd0, memwb_flush}, 0);
    step();
    chk("miss_stall_cnt", {16'd0, stall_cnt}, 3);

    // Mispredict masked by a data stall
    do_reset();
    ihit = 1; exmem_dren = 1; dhit = 0; ex_mispredict = 1;
    #1;
    chk("mpds_ifid_flush", {31'd0, ifid_flush}, 0);
    chk("mpds_pc_en", {31'd0, pc_en}, 0);
    step();
    dhit = 1;
    #1;
    chk("mp_ifid_flush", {31'd0, ifid_flush}, 1);
    chk("mp_idex_flush", {31'd0, idex_flush}, 1);
    chk("mp_pc_en", {31'd0, pc_en}, 1);
    step();
    chk("mp_flush_cnt", {16'd0, flush_cnt}, 1);

    // Halt drain
    do_reset();
    ihit = 1; idex_halt = 1;
    step();
    idex_halt = 0;
    #1;
    chk("drain_pc_en", {31'd0, pc_en}, 0);
    chk("drain_ifid_flush", {31'd0, ifid_flush}, 1);
    step();
    memwb_halt = 1;
    #1;
    chk("pre_halt", {31'd0, halt}, 0);
    step();
    memwb_halt = 0;
    #1;
    chk("halt_set", {31'd0, halt}, 1);
    chk("halt_ens", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
    step();
    chk("halt_sticky", {31'd0, halt}, 1);
    chk("halt_pc_en", {31'd0, pc_en}, 0);

    // Saturation on the 4-bit instance
    do_reset();
    ihit = 0;
    repeat (20) step();
    chk("sat_stall4", {28'd0, stall_cnt4}, 15);
    chk("sat_stall16", {16'd0, stall_cnt}, 20);

    // Asynchronous reset mid-drain
    do_reset();
    ihit = 0; idex_halt = 1;
    step();
    idex_halt = 0;
    step();
    chk("pre_rst_stall", {16'd0, stall_cnt}, 2);
    ihit = 1;
    #1;
    chk("pre_rst_pc_en", {31'd0, pc_en}, 0);
    nrst = 0;
    #1;
    chk("arst_stall", {16'd0, stall_cnt}, 0);
    chk("arst_halt", {31'd0, halt}, 0);
    chk("arst_pc_en", {31'd0, pc_en}, 1);
    step();
    nrst = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      nrst          = ($urandom_range(0, 59) != 0);
      ihit          = ($urandom_range(0, 3) != 0);
      dhit          = ($urandom_range(0, 2) != 0);
      exmem_dren    = ($urandom_range(0, 3) == 0);
      exmem_dwen    = ($urandom_range(0, 5) == 0);
      idex_dren     = ($urandom_range(0, 2) == 0);
      idex_wsel     = 5'($urandom_range(0, 3));
      ifid_rs       = 5'($urandom_range(0, 3));
      ifid_rt       = 5'($urandom_range(0, 3));
      ex_mispredict = ($urandom_range(0, 5) == 0);
      idex_halt     = ($urandom_range(0, 19) == 0);
      memwb_halt    = ($urandom_range(0, 39) == 0);
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
